// File: rtl/rv32i_types.sv
// Shared types for the store drain path: store width encodings and the
// commit-unit state machine encoding.
package rv32i_types;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } sc_state_t;

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: turns a byte address, store width and
// raw register data into a word address, replicated write data, byte enables
// and a flag for misaligned or unsupported stores.
module store_align
    import rv32i_types::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] data,
    output logic [31:0] aligned_addr,
    output logic [31:0] wdata,
    output logic [3:0]  mbe,
    output logic        misaligned
);

    assign aligned_addr = {addr[31:2], 2'b00};

    // Replicate the store data across every lane it could land in and pick
    // the byte enables from the low address bits; unknown widths are illegal.
    always_comb begin
        wdata      = 32'h0;
        mbe        = 4'h0;
        misaligned = 1'b1;
        case (store_funct3_t'(funct3))
            sb: begin
                wdata      = {4{data[7:0]}};
                mbe        = 4'b0001 << addr[1:0];
                misaligned = 1'b0;
            end
            sh: begin
                wdata      = {2{data[15:0]}};
                mbe        = 4'b0011 << addr[1:0];
                misaligned = addr[0];
            end
            sw: begin
                wdata      = data;
                mbe        = 4'hF;
                misaligned = |addr[1:0];
            end
            default: begin
                wdata      = 32'h0;
                mbe        = 4'h0;
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_commit_unit.sv
// Drain side of the store queue. Waits until the ROB commits the store sitting
// at the queue head, writes it to data memory, then pops the head and reports
// completion (with an exception flag for misaligned/illegal stores).
module store_commit_unit
    import rv32i_types::*;
#(
    parameter int ID_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sq_head_ready,
    input  logic [ID_W-1:0] sq_head_id,
    input  logic [31:0]     sq_head_address,
    input  logic [31:0]     sq_head_data,
    input  logic [2:0]      sq_head_funct3,
    output logic            sq_del_head,
    input  logic            rob_commit_valid,
    input  logic [ID_W-1:0] rob_commit_id,
    input  logic            flush,
    output logic [31:0]     dmem_address,
    output logic [31:0]     dmem_wdata,
    output logic [3:0]      dmem_mbe,
    output logic            dmem_write,
    input  logic            dmem_resp,
    output logic            st_done,
    output logic [ID_W-1:0] st_done_id,
    output logic            st_except,
    output logic            st_timeout,
    output logic            busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sc_state_t  state;
    sc_state_t  next_state;
    logic       start;
    logic [CNT_W-1:0] wait_cnt;

    logic [31:0] al_addr;
    logic [31:0] al_wdata;
    logic [3:0]  al_mbe;
    logic        al_misaligned;

    store_align u_align (
        .addr         (sq_head_address),
        .funct3       (sq_head_funct3),
        .data         (sq_head_data),
        .aligned_addr (al_addr),
        .wdata        (al_wdata),
        .mbe          (al_mbe),
        .misaligned   (al_misaligned)
    );

    assign busy = (state != IDLE);

    // State register; an async reset abandons any in-flight write without popping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start only when the committing ROB head is the store at the queue head;
    // bad stores skip the memory write and go straight to reporting.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (sq_head_ready && rob_commit_valid &&
                    (rob_commit_id == sq_head_id) && !flush) begin
                    start      = 1'b1;
                    next_state = al_misaligned ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (dmem_resp) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered outputs: latch the head at start, hold the write until the
    // acknowledge, raise the one-cycle pop/done pulses and track the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_address <= 32'h0;
            dmem_wdata   <= 32'h0;
            dmem_mbe     <= 4'h0;
            dmem_write   <= 1'b0;
            sq_del_head  <= 1'b0;
            st_done      <= 1'b0;
            st_done_id   <= '0;
            st_except    <= 1'b0;
            st_timeout   <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            sq_del_head <= 1'b0;
            st_done     <= 1'b0;
            st_except   <= 1'b0;
            if (start) begin
                dmem_address <= al_addr;
                dmem_wdata   <= al_wdata;
                dmem_mbe     <= al_mbe;
                st_done_id   <= sq_head_id;
                wait_cnt     <= '0;
                dmem_write   <= !al_misaligned;
                if (al_misaligned) begin
                    sq_del_head <= 1'b1;
                    st_done     <= 1'b1;
                    st_except   <= 1'b1;
                end
            end else if (state == ISSUE) begin
                if (wait_cnt != CNT_W'(TIMEOUT)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    st_timeout <= 1'b1;
                end
                if (dmem_resp) begin
                    dmem_write  <= 1'b0;
                    sq_del_head <= 1'b1;
                    st_done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_commit_unit.sv
// Self-checking bench for store_commit_unit: a table of stores driven one at a
// time with a scoreboard checking the memory write and the completion report,
// plus hand-written sequences for id mismatch, flush, timeout and reset.
module tb_store_commit_unit;

    localparam int ID_W = 5;

    logic            clk;
    logic            rst;
    logic            sq_head_ready;
    logic [ID_W-1:0] sq_head_id;
    logic [31:0]     sq_head_address;
    logic [31:0]     sq_head_data;
    logic [2:0]      sq_head_funct3;
    logic            sq_del_head;
    logic            rob_commit_valid;
    logic [ID_W-1:0] rob_commit_id;
    logic            flush;
    logic [31:0]     dmem_address;
    logic [31:0]     dmem_wdata;
    logic [3:0]      dmem_mbe;
    logic            dmem_write;
    logic            dmem_resp;
    logic            st_done;
    logic [ID_W-1:0] st_done_id;
    logic            st_except;
    logic            st_timeout;
    logic            busy;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [2:0]      funct3;
        logic            legal;
        logic [31:0]     exp_addr;
        logic [31:0]     exp_wdata;
        logic [3:0]      exp_mbe;
    } vec_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic            legal;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [3:0]      mbe;
    } scb_t;

    scb_t sb[$];
    scb_t popped;
    vec_t vecs[9];
    int   assertions = 0;
    int   failures   = 0;

    store_commit_unit #(.ID_W(ID_W), .TIMEOUT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .sq_head_ready    (sq_head_ready),
        .sq_head_id       (sq_head_id),
        .sq_head_address  (sq_head_address),
        .sq_head_data     (sq_head_data),
        .sq_head_funct3   (sq_head_funct3),
        .sq_del_head      (sq_del_head),
        .rob_commit_valid (rob_commit_valid),
        .rob_commit_id    (rob_commit_id),
        .flush            (flush),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_mbe         (dmem_mbe),
        .dmem_write       (dmem_write),
        .dmem_resp        (dmem_resp),
        .st_done          (st_done),
        .st_done_id       (st_done_id),
        .st_except        (st_except),
        .st_timeout       (st_timeout),
        .busy             (busy)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every write cycle must match the oldest pending store,
    // every completion pops it and checks tag and exception flag.
    always @(negedge clk) begin
        if (dmem_write) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", dmem_write, 0);
            end else begin
                checkOutput("write_legal", dmem_write, {31'b0, sb[0].legal});
                checkOutput("dmem_address", dmem_address, sb[0].addr);
                checkOutput("dmem_wdata", dmem_wdata, sb[0].wdata);
                checkOutput("dmem_mbe", dmem_mbe, {28'b0, sb[0].mbe});
            end
        end
        if (st_done || sq_del_head) begin
            checkOutput("pop_with_done", sq_del_head, st_done);
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", st_done, 0);
            end else if (st_done) begin
                popped = sb.pop_front();
                checkOutput("st_done_id", st_done_id, {27'b0, popped.id});
                checkOutput("st_except", st_except, {31'b0, !popped.legal});
            end
        end
    end

    // Present one store at the head with a matching commit, then scramble the
    // head and hold flush while busy; legal stores get a response two cycles in.
    task automatic applyStimulus(input vec_t v);
        scb_t e;
        @(negedge clk);
        sq_head_ready    = 1'b1;
        sq_head_id       = v.id;
        sq_head_address  = v.addr;
        sq_head_data     = v.data;
        sq_head_funct3   = v.funct3;
        rob_commit_valid = 1'b1;
        rob_commit_id    = v.id;
        e.id    = v.id;
        e.legal = v.legal;
        e.addr  = v.exp_addr;
        e.wdata = v.exp_wdata;
        e.mbe   = v.exp_mbe;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sq_head_ready    = 1'b0;
        rob_commit_valid = 1'b0;
        sq_head_address  = $urandom;
        sq_head_data     = $urandom;
        sq_head_funct3   = 3'b010;
        sq_head_id       = v.id + 1'b1;
        flush            = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_start", busy, 1);
        if (v.legal) begin
            checkOutput("write_issued", dmem_write, 1);
            @(negedge clk);
            dmem_resp = 1'b1;
            @(posedge clk);
            #1;
            dmem_resp = 1'b0;
            @(negedge clk);
            checkOutput("done_after_resp", st_done, 1);
        end else begin
            checkOutput("illegal_done", st_done, 1);
            checkOutput("illegal_no_write", dmem_write, 0);
        end
        flush = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_done", busy, 0);
        checkOutput("done_pulse_width", st_done, 0);
    endtask

    initial begin
        vecs[0] = '{5'd3,  32'h1000_0004, 32'hDEAD_BEEF, 3'b010, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF};
        vecs[1] = '{5'd5,  32'h2000_0003, 32'h0000_00AB, 3'b000, 1'b1, 32'h2000_0000, 32'hABAB_ABAB, 4'b1000};
        vecs[2] = '{5'd6,  32'h2000_0001, 32'h1234_5678, 3'b000, 1'b1, 32'h2000_0000, 32'h7878_7878, 4'b0010};
        vecs[3] = '{5'd7,  32'h3000_0002, 32'hCAFE_1234, 3'b001, 1'b1, 32'h3000_0000, 32'h1234_1234, 4'b1100};
        vecs[4] = '{5'd8,  32'h3000_0000, 32'h0000_BEEF, 3'b001, 1'b1, 32'h3000_0000, 32'hBEEF_BEEF, 4'b0011};
        vecs[5] = '{5'd9,  32'h2000_0001, 32'h0000_1111, 3'b001, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[6] = '{5'd10, 32'h4000_0002, 32'h5555_5555, 3'b010, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[7] = '{5'd11, 32'h0000_0000, 32'h7777_7777, 3'b011, 1'b0, 32'h0, 32'h0, 4'h0};
        vecs[8] = '{5'd31, 32'h0000_0000, 32'h0000_0000, 3'b010, 1'b1, 32'h0000_0000, 32'h0000_0000, 4'hF};

        rst              = 1'b0;
        sq_head_ready    = 1'b0;
        sq_head_id       = '0;
        sq_head_address  = 32'h0;
        sq_head_data     = 32'h0;
        sq_head_funct3   = 3'b000;
        rob_commit_valid = 1'b0;
        rob_commit_id    = '0;
        flush            = 1'b0;
        dmem_resp        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_write", dmem_write, 0);
        checkOutput("reset_done", st_done, 0);
        checkOutput("reset_del_head", sq_del_head, 0);
        checkOutput("reset_timeout", st_timeout, 0);
        checkOutput("reset_address", dmem_address, 0);
        checkOutput("reset_mbe", dmem_mbe, 0);
        rst = 1'b1;

        // Table of single stores
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Commit id does not match the head: no start
        @(negedge clk);
        sq_head_ready    = 1'b1;
        sq_head_id       = 5'd3;
        sq_head_address  = 32'h1000_0004;
        sq_head_funct3   = 3'b010;
        rob_commit_valid = 1'b1;
        rob_commit_id    = 5'd4;
        repeat (3) @(negedge clk);
        checkOutput("mismatch_busy", busy, 0);
        checkOutput("mismatch_del_head", sq_del_head, 0);

        // Matching id but flush held: no start
        rob_commit_id = 5'd3;
        flush         = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("flush_busy", busy, 0);
        checkOutput("flush_del_head", sq_del_head, 0);
        sq_head_ready    = 1'b0;
        rob_commit_valid = 1'b0;
        flush            = 1'b0;

        // Stray response while idle is ignored
        @(negedge clk);
        dmem_resp = 1'b1;
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        checkOutput("stray_resp_busy", busy, 0);
        checkOutput("stray_resp_done", st_done, 0);

        // Timeout: no response for 8 ISSUE cycles, then a late response
        @(negedge clk);
        sq_head_ready    = 1'b1;
        sq_head_id       = vecs[0].id;
        sq_head_address  = vecs[0].addr;
        sq_head_data     = vecs[0].data;
        sq_head_funct3   = vecs[0].funct3;
        rob_commit_valid = 1'b1;
        rob_commit_id    = vecs[0].id;
        sb.push_back('{vecs[0].id, 1'b1, vecs[0].exp_addr, vecs[0].exp_wdata, vecs[0].exp_mbe});
        @(posedge clk);
        #1;
        sq_head_ready    = 1'b0;
        rob_commit_valid = 1'b0;
        for (int j = 1; j <= 8; j++) @(negedge clk);
        checkOutput("timeout_not_yet", st_timeout, 0);
        @(negedge clk);
        checkOutput("timeout_set", st_timeout, 1);
        repeat (2) @(negedge clk);
        checkOutput("timeout_sticky", st_timeout, 1);
        checkOutput("timeout_still_writing", dmem_write, 1);
        dmem_resp = 1'b1;
        @(posedge clk);
        #1;
        dmem_resp = 1'b0;
        @(negedge clk);
        checkOutput("late_resp_done", st_done, 1);
        checkOutput("timeout_held_at_done", st_timeout, 1);
        @(negedge clk);
        checkOutput("late_resp_idle", busy, 0);

        // Reset in the middle of ISSUE
        @(negedge clk);
        sq_head_ready    = 1'b1;
        sq_head_id       = vecs[1].id;
        sq_head_address  = vecs[1].addr;
        sq_head_data     = vecs[1].data;
        sq_head_funct3   = vecs[1].funct3;
        rob_commit_valid = 1'b1;
        rob_commit_id    = vecs[1].id;
        sb.push_back('{vecs[1].id, 1'b1, vecs[1].exp_addr, vecs[1].exp_wdata, vecs[1].exp_mbe});
        @(posedge clk);
        #1;
        sq_head_ready    = 1'b0;
        rob_commit_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_write", dmem_write, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("reset_drops_write", dmem_write, 0);
        checkOutput("reset_clears_busy", busy, 0);
        checkOutput("reset_clears_timeout", st_timeout, 0);
        sb.delete();
        @(negedge clk);
        checkOutput("reset_no_pop", sq_del_head, 0);
        checkOutput("reset_no_done", st_done, 0);
        rst = 1'b1;

        // Retry of the abandoned store completes normally
        applyStimulus(vecs[1]);

        @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
